// File: rtl/fwft_packetizer.sv
// fwft_packetizer: frames 20-bit FWFT FIFO samples into headered, MSB-first bit-packed 16-bit packets
module fwft_packetizer #(
    parameter int PKT_SAMPLES = 64
) (
    input  logic        CLK,
    input  logic        reset,
    input  logic [19:0] DI,
    input  logic        EMPTY,
    output logic        RDEN,
    output logic [15:0] DO,
    output logic        WREN,
    input  logic        FULL,
    output logic        LAST,
    output logic        BUSY
);
    localparam logic [10:0] FINAL_CNT = 11'(5 * PKT_SAMPLES / 4 - 1);
    // The header is loaded on leaving IDLE, so header-in-flight is PAYLOAD with cnt==0.
    typedef enum logic {IDLE, PAYLOAD} state_t;
    state_t      state, state_n;
    logic [7:0]  seq, seq_n;
    logic [10:0] cnt, cnt_n;
    logic [2:0]  phase, phase_n;
    logic [15:0] res, res_n, res_ld, word, do_n;
    logic        wren_n, last_n, slot_free, fin;
    assign slot_free = !WREN || !FULL;
    assign fin       = cnt == FINAL_CNT;
    assign BUSY      = state != IDLE;
    assign RDEN      = !reset && state == PAYLOAD && slot_free && !EMPTY && phase != 3'd4;
    assign word   = phase == 3'd0 ? DI[19:4] :
                    phase == 3'd1 ? {res[3:0], DI[19:8]} :
                    phase == 3'd2 ? {res[7:0], DI[19:12]} :
                    phase == 3'd3 ? {res[11:0], DI[19:16]} : res;
    assign res_ld = phase == 3'd0 ? {12'h000, DI[3:0]} :
                    phase == 3'd1 ? {8'h00, DI[7:0]} :
                    phase == 3'd2 ? {4'h0, DI[11:0]} :
                    phase == 3'd3 ? DI[15:0] : res;
    always_comb begin
        state_n = state;
        seq_n   = seq;
        cnt_n   = cnt;
        phase_n = phase;
        res_n   = res;
        do_n    = DO;
        wren_n  = WREN;
        last_n  = LAST;
        if (slot_free) begin
            wren_n = 1'b0;
            last_n = 1'b0;
            if (state == IDLE) begin
                if (!EMPTY) begin
                    do_n    = {8'hA5, seq};
                    wren_n  = 1'b1;
                    cnt_n   = '0;
                    phase_n = '0;
                    state_n = PAYLOAD;
                end
            end else if (phase == 3'd4 || !EMPTY) begin
                do_n    = word;
                wren_n  = 1'b1;
                last_n  = fin;
                res_n   = res_ld;
                cnt_n   = cnt + 11'd1;
                phase_n = phase == 3'd4 ? 3'd0 : phase + 3'd1;
                if (fin) begin
                    seq_n   = seq + 8'd1;
                    state_n = IDLE;
                end
            end
        end
    end
    always_ff @(posedge CLK) begin
        if (reset) begin
            state <= IDLE;
            seq   <= '0;
            cnt   <= '0;
            phase <= '0;
            res   <= '0;
            DO    <= '0;
            WREN  <= 1'b0;
            LAST  <= 1'b0;
        end else begin
            state <= state_n;
            seq   <= seq_n;
            cnt   <= cnt_n;
            phase <= phase_n;
            res   <= res_n;
            DO    <= do_n;
            WREN  <= wren_n;
            LAST  <= last_n;
        end
    end
endmodule

// File: tb/tb_fwft_packetizer.sv
// tb_fwft_packetizer: scoreboard bench; stimulus queues samples and expected words, a monitor checks transfers
module tb_fwft_packetizer;
    logic        CLK = 1'b0;
    logic        reset = 1'b1;
    logic [19:0] DI = '0;
    logic        EMPTY = 1'b1;
    logic        FULL = 1'b0;
    logic        RDEN, WREN, LAST, BUSY;
    logic [15:0] DO;

    fwft_packetizer #(.PKT_SAMPLES(4)) dut (
        .CLK(CLK), .reset(reset), .DI(DI), .EMPTY(EMPTY), .RDEN(RDEN),
        .DO(DO), .WREN(WREN), .FULL(FULL), .LAST(LAST), .BUSY(BUSY)
    );

    always #5 CLK = ~CLK;

    logic [19:0] fifo[$];
    logic [16:0] exp_q[$];
    logic [16:0] mon_e;
    logic [7:0]  exp_seq = '0;
    int total = 0, bad = 0, nxfer = 0, nlast = 0, npop = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
        total++;
        if (act !== req) begin
            bad++;
            $display("FAIL %s: got %0h want %0h", name, act, req);
        end
    endtask

    task automatic drive();
        EMPTY = fifo.size() == 0;
        DI    = EMPTY ? 20'h0 : fifo[0];
    endtask

    // decide the pop away from the edge, apply it just after the edge
    task automatic tick();
        logic pop;
        @(negedge CLK);
        pop = RDEN;
        if (reset || EMPTY || (FULL && WREN)) check("rden_gate", 32'(RDEN), 32'd0);
        @(posedge CLK);
        #1;
        if (pop && fifo.size() != 0) begin
            void'(fifo.pop_front());
            npop++;
        end
        drive();
    endtask

    task automatic push_exp(input logic [15:0] w, input logic l);
        exp_q.push_back({w, l});
    endtask

    task automatic push_pkt(input logic [19:0] a, input logic [19:0] b, input logic [19:0] c, input logic [19:0] d);
        logic [79:0] v;
        v = {a, b, c, d};
        push_exp({8'hA5, exp_seq}, 1'b0);
        exp_seq++;
        for (int i = 0; i < 5; i++) push_exp(v[79 - 16 * i -: 16], i == 4);
        fifo.push_back(a);
        fifo.push_back(b);
        fifo.push_back(c);
        fifo.push_back(d);
    endtask

    task automatic wait_drain(input int maxc, input bit jitter);
        int n;
        n = 0;
        while (exp_q.size() != 0 && n < maxc) begin
            if (jitter) FULL = $urandom_range(0, 3) == 0;
            tick();
            n++;
        end
        FULL = 1'b0;
        check("drain_timeout", 32'(exp_q.size()), 32'd0);
    endtask

    always @(negedge CLK) begin
        if (!reset && WREN && !FULL) begin
            nxfer++;
            if (LAST) nlast++;
            if (exp_q.size() == 0) begin
                total++;
                bad++;
                $display("FAIL unexpected_word: got %h last %b want none", DO, LAST);
            end else begin
                mon_e = exp_q.pop_front();
                check("word", 32'({DO, LAST}), 32'(mon_e));
            end
        end
    end

    initial begin
        int p0, x0, l0;
        // test 1: reset with FIFO non-empty
        fifo = '{20'h12345, 20'h6789A, 20'hBCDEF, 20'h01234};
        drive();
        repeat (2) tick();
        check("reset_rden", 32'(RDEN), 32'd0);
        check("reset_outs", 32'({WREN, LAST, BUSY, DO}), 32'd0);
        // test 2: one packet, no backpressure, back-to-back words
        push_exp(16'hA500, 0); push_exp(16'h1234, 0); push_exp(16'h5678, 0);
        push_exp(16'h9ABC, 0); push_exp(16'hDEF0, 0); push_exp(16'h1234, 1);
        p0 = npop; x0 = nxfer; l0 = nlast;
        reset = 1'b0;
        repeat (7) tick();
        check("t2_words", 32'(nxfer - x0), 32'd6);
        check("t2_pops", 32'(npop - p0), 32'd4);
        check("t2_last", 32'(nlast - l0), 32'd1);
        check("t2_idle", 32'({WREN, BUSY}), 32'd0);
        // test 3: FULL held for 3 cycles while DO=5678
        fifo = '{20'h12345, 20'h6789A, 20'hBCDEF, 20'h01234};
        push_exp(16'hA501, 0); push_exp(16'h1234, 0); push_exp(16'h5678, 0);
        push_exp(16'h9ABC, 0); push_exp(16'hDEF0, 0); push_exp(16'h1234, 1);
        p0 = npop;
        drive();
        repeat (3) tick();
        FULL = 1'b1;
        repeat (3) begin
            tick();
            check("t3_hold", 32'({WREN, DO}), 32'h15678);
        end
        check("t3_held_pops", 32'(npop - p0), 32'd2);
        FULL = 1'b0;
        wait_drain(20, 0);
        check("t3_pops", 32'(npop - p0), 32'd4);
        // test 4: FIFO runs dry before the 4th sample
        fifo = '{20'h12345, 20'h6789A, 20'hBCDEF};
        push_exp(16'hA502, 0); push_exp(16'h1234, 0); push_exp(16'h5678, 0);
        push_exp(16'h9ABC, 0); push_exp(16'hDEF0, 0); push_exp(16'h1234, 1);
        drive();
        repeat (4) tick();
        repeat (2) begin
            tick();
            check("t4_bubble", 32'({WREN, BUSY}), 32'd1);
        end
        fifo.push_back(20'h01234);
        drive();
        repeat (2) tick();
        check("t4_phase4", 32'({WREN, LAST, EMPTY, DO}), 32'h71234);
        wait_drain(10, 0);
        // test 6: reset mid-packet, then a fresh packet
        fifo = '{20'h12345, 20'h6789A};
        push_exp(16'hA503, 0); push_exp(16'h1234, 0); push_exp(16'h5678, 0);
        drive();
        wait_drain(20, 0);
        reset = 1'b1;
        tick();
        check("t6_reset_outs", 32'({WREN, LAST, BUSY}), 32'd0);
        reset = 1'b0;
        exp_seq = '0;
        fifo = '{20'hABCDE, 20'hF0123, 20'h45678, 20'h9ABCD};
        push_exp(16'hA500, 0); push_exp(16'hABCD, 0); push_exp(16'hEF01, 0);
        push_exp(16'h2345, 0); push_exp(16'h6789, 0); push_exp(16'hABCD, 1);
        drive();
        wait_drain(30, 0);
        // test 5: 257 packets with random backpressure, header wraps A5FF -> A500
        reset = 1'b1;
        tick();
        reset = 1'b0;
        exp_seq = '0;
        l0 = nlast;
        for (int p = 0; p < 257; p++)
            push_pkt(20'($urandom), 20'($urandom), 20'($urandom), 20'($urandom));
        drive();
        wait_drain(257 * 6 * 2 + 100, 1);
        check("t5_last_count", 32'(nlast - l0), 32'd257);
        check("t5_fifo_empty", 32'(fifo.size()), 32'd0);
        repeat (2) tick();
        check("final_idle", 32'({WREN, BUSY}), 32'd0);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
